// File: rtl/sequenciador_multiciclo_if.sv
// Control bundle between the nrisc multicycle sequencer and its datapath.
// master = sequencer side (drives strobes), slave = datapath/memory side.
interface sequenciador_multiciclo_if;
    logic [7:0]  instr;
    logic        mem_pronta;
    logic        zero;
    logic        MemRead;
    logic        MemWrite;
    logic        EscIR;
    logic        EscPC;
    logic        PCsrc;
    logic        EscReg;
    logic        MemParaReg;
    logic        ULAsrcB;
    logic [1:0]  ULAOp;
    logic        Slt;
    logic        halt;
    logic        erro;
    logic [2:0]  estado;
    logic [15:0] contador_instr;

    modport master (
        input  instr, mem_pronta, zero,
        output MemRead, MemWrite, EscIR, EscPC, PCsrc, EscReg, MemParaReg,
               ULAsrcB, ULAOp, Slt, halt, erro, estado, contador_instr
    );

    modport slave (
        output instr, mem_pronta, zero,
        input  MemRead, MemWrite, EscIR, EscPC, PCsrc, EscReg, MemParaReg,
               ULAsrcB, ULAOp, Slt, halt, erro, estado, contador_instr
    );
endinterface

// File: rtl/sequenciador_multiciclo.sv
// nrisc multicycle sequencer: fetch/decode/exec/mem/writeback FSM with
// memory ready/timeout handshake, sticky halt/error and retired count.
module sequenciador_multiciclo #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic                      clk,
    input logic                      rst_n,
    sequenciador_multiciclo_if.master bus
);
    typedef enum logic [2:0] {
        INICIO = 3'd0, BUSCA = 3'd1, DECOD = 3'd2, EXEC = 3'd3,
        MEM    = 3'd4, ESCR  = 3'd5, HALT  = 3'd6, ERRO = 3'd7
    } estado_t;

    // Last allowed wait count; one more idle cycle trips the error.
    localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

    estado_t     estado_q, estado_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  funct_q, funct_d;
    logic [7:0]  espera_q, espera_d;
    logic [15:0] contador_q, contador_d;

    logic       retira, ctrl_en;
    logic       mem_rd, mem_wr, esc_ir, esc_pc, pc_src, esc_reg, mem_p_reg;
    logic       ula_src_b, slt_sel;
    logic [1:0] ula_op;
    logic       is_load, is_store, is_beq;

    // Register field bits the sequencer never looks at.
    logic unused_instr;
    assign unused_instr = ^bus.instr[4:2];

    assign is_load  = (op_q == 3'b010);
    assign is_store = (op_q == 3'b011);
    assign is_beq   = (op_q == 3'b111);

    // ULA controls per latched instruction; gated to EXEC/MEM/ESCR below.
    always_comb begin
        ula_op    = 2'b00;
        ula_src_b = 1'b0;
        slt_sel   = 1'b0;
        case (op_q)
            3'b001, 3'b010, 3'b011: ula_src_b = 1'b1;
            3'b100, 3'b101: begin
                ula_op  = 2'b01;
                slt_sel = 1'b1;
            end
            3'b110: begin
                case (funct_q)
                    2'b00: ula_op = 2'b01;
                    2'b01: ula_op = 2'b10;
                    2'b10: begin
                        ula_op    = 2'b11;
                        ula_src_b = 1'b1;
                    end
                    default: ula_op = 2'b00;
                endcase
            end
            3'b111: ula_op = 2'b01;
            default: ula_op = 2'b00;
        endcase
    end

    // Next-state, strobes, wait counter and retire pulse.
    always_comb begin
        estado_d  = estado_q;
        op_d      = op_q;
        funct_d   = funct_q;
        espera_d  = 8'd0;
        retira    = 1'b0;
        ctrl_en   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        esc_ir    = 1'b0;
        esc_pc    = 1'b0;
        pc_src    = 1'b0;
        esc_reg   = 1'b0;
        mem_p_reg = 1'b0;
        case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
                mem_rd = 1'b1;
                if (bus.mem_pronta) begin
                    esc_ir   = 1'b1;
                    esc_pc   = 1'b1;
                    estado_d = DECOD;
                end else if (espera_q == LIMITE) begin
                    estado_d = ERRO;
                end else begin
                    espera_d = espera_q + 8'd1;
                end
            end
            DECOD: begin
                op_d    = bus.instr[7:5];
                funct_d = bus.instr[1:0];
                if (bus.instr[7:5] == 3'b110 && bus.instr[1:0] == 2'b11) begin
                    estado_d = HALT;
                    retira   = 1'b1;
                end else begin
                    estado_d = EXEC;
                end
            end
            EXEC: begin
                ctrl_en = 1'b1;
                if (is_load || is_store) begin
                    estado_d = MEM;
                end else if (is_beq) begin
                    esc_pc   = bus.zero;
                    pc_src   = bus.zero;
                    estado_d = BUSCA;
                    retira   = 1'b1;
                end else begin
                    estado_d = ESCR;
                end
            end
            MEM: begin
                ctrl_en = 1'b1;
                mem_rd  = is_load;
                mem_wr  = !is_load;
                if (bus.mem_pronta) begin
                    estado_d = is_load ? ESCR : BUSCA;
                    retira   = !is_load;
                end else if (espera_q == LIMITE) begin
                    estado_d = ERRO;
                end else begin
                    espera_d = espera_q + 8'd1;
                end
            end
            ESCR: begin
                ctrl_en   = 1'b1;
                esc_reg   = 1'b1;
                mem_p_reg = is_load;
                estado_d  = BUSCA;
                retira    = 1'b1;
            end
            default: estado_d = estado_q;   // HALT, ERRO: wait for reset
        endcase
        contador_d = contador_q + 16'(retira);
    end

    // State, latched opcode, wait and retired counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= INICIO;
            op_q       <= 3'd0;
            funct_q    <= 2'd0;
            espera_q   <= 8'd0;
            contador_q <= 16'd0;
        end else begin
            estado_q   <= estado_d;
            op_q       <= op_d;
            funct_q    <= funct_d;
            espera_q   <= espera_d;
            contador_q <= contador_d;
        end
    end

    assign bus.MemRead        = mem_rd;
    assign bus.MemWrite       = mem_wr;
    assign bus.EscIR          = esc_ir;
    assign bus.EscPC          = esc_pc;
    assign bus.PCsrc          = pc_src;
    assign bus.EscReg         = esc_reg;
    assign bus.MemParaReg     = mem_p_reg;
    assign bus.ULAsrcB        = ctrl_en & ula_src_b;
    assign bus.ULAOp          = ctrl_en ? ula_op : 2'b00;
    assign bus.Slt            = ctrl_en & slt_sel;
    assign bus.halt           = (estado_q == HALT);
    assign bus.erro           = (estado_q == ERRO);
    assign bus.estado         = estado_q;
    assign bus.contador_instr = contador_q;
endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench for sequenciador_multiciclo: main instance at default
// TIMEOUT plus a TIMEOUT=4 instance for the memory-timeout path.
module tb_sequenciador_multiciclo;
    logic clk;
    logic rst_n, rst4_n;
    int   checks, failures;
    int   exp_cnt;

    sequenciador_multiciclo_if bus();
    sequenciador_multiciclo_if bus4();

    sequenciador_multiciclo dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    sequenciador_multiciclo #(.TIMEOUT(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the last run_instr walk.
    int          r_cyc, r_reg, r_mpr, r_mrd_mem, r_mwr, r_ir;
    logic        r_pcex, r_pcsrc;
    logic [3:0]  r_ctrl;
    logic [23:0] r_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [12:0] strb();
        return {bus.MemRead, bus.MemWrite, bus.EscIR, bus.EscPC, bus.PCsrc,
                bus.EscReg, bus.MemParaReg, bus.ULAsrcB, bus.ULAOp, bus.Slt,
                bus.halt, bus.erro};
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction from the start of a BUSCA cycle back to the next
    // BUSCA; mem_pronta drops for 'waits' cycles inside MEM.
    task automatic run_instr(input logic [7:0] ins, input int waits, input logic z);
        int w;
        w = 0;
        r_cyc = 0; r_reg = 0; r_mpr = 0; r_mrd_mem = 0; r_mwr = 0; r_ir = 0;
        r_pcex = 1'b0; r_pcsrc = 1'b0; r_ctrl = 4'd0; r_seq = 24'd0;
        bus.instr = ins;
        bus.zero  = z;
        for (int n = 0; n < 40; n++) begin
            if (n > 0 && bus.estado == 3'd1) break;
            if (bus.estado == 3'd4 && w < waits) begin
                bus.mem_pronta = 1'b0;
                w++;
            end else begin
                bus.mem_pronta = 1'b1;
            end
            @(negedge clk);
            r_seq = {r_seq[20:0], bus.estado};
            r_cyc++;
            if (bus.estado == 3'd3) begin
                r_ctrl  = {bus.ULAsrcB, bus.ULAOp, bus.Slt};
                r_pcex  = bus.EscPC;
                r_pcsrc = bus.PCsrc;
            end
            if (bus.estado == 3'd4) begin
                r_mrd_mem += int'(bus.MemRead);
                r_mwr     += int'(bus.MemWrite);
            end
            r_reg += int'(bus.EscReg);
            r_mpr += int'(bus.MemParaReg);
            r_ir  += int'(bus.EscIR);
            adv();
        end
        chk("back_to_busca", 32'(bus.estado), 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [7:0] ins, input int waits,
                             input logic z, input int e_cyc, input logic [3:0] e_ctrl,
                             input int e_reg);
        run_instr(ins, waits, z);
        exp_cnt++;
        chk({tag, "_cyc"},  32'(r_cyc),  32'(e_cyc));
        chk({tag, "_ctrl"}, 32'(r_ctrl), 32'(e_ctrl));
        chk({tag, "_reg"},  32'(r_reg),  32'(e_reg));
        chk({tag, "_ir"},   32'(r_ir),   32'd1);
        chk({tag, "_cnt"},  32'(bus.contador_instr), 32'(exp_cnt));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; exp_cnt = 0;
        rst_n = 1'b0; rst4_n = 1'b0;
        bus.instr = 8'h00; bus.mem_pronta = 1'b1; bus.zero = 1'b1;
        bus4.instr = 8'h00; bus4.mem_pronta = 1'b0; bus4.zero = 1'b0;
        #2;
        chk("rst_estado", 32'(bus.estado), 32'd0);
        chk("rst_cnt", 32'(bus.contador_instr), 32'd0);
        chk("rst_strb", 32'(strb()), 32'd0);

        // Reset release: one INICIO cycle, then add with zero-wait memory.
        adv();
        rst_n = 1'b1;
        bus.zero = 1'b0;
        chk("inicio_estado", 32'(bus.estado), 32'd0);
        @(negedge clk);
        chk("inicio_strb", 32'(strb()), 32'd0);
        adv();
        run_check("add", 8'h00, 0, 1'b0, 4, 4'b0000, 1);
        chk("add_seq", 32'(r_seq), 32'o1235);

        // load with 3 wait cycles in MEM
        run_check("load", 8'h40, 3, 1'b1, 8, 4'b1000, 1);
        chk("load_seq", 32'(r_seq), 32'o12344445);
        chk("load_mrd", 32'(r_mrd_mem), 32'd4);
        chk("load_mpr", 32'(r_mpr), 32'd1);

        // beq taken then not taken
        run_check("beq_t", 8'hE0, 0, 1'b1, 3, 4'b0010, 0);
        chk("beq_t_pc", 32'({r_pcex, r_pcsrc}), 32'b11);
        run_check("beq_n", 8'hE0, 0, 1'b0, 3, 4'b0010, 0);
        chk("beq_n_pc", 32'({r_pcex, r_pcsrc}), 32'b00);

        // remaining instruction classes
        run_check("addi",  8'h20, 0, 1'b1, 4, 4'b1000, 1);
        run_check("slt0",  8'h80, 0, 1'b0, 4, 4'b0011, 1);
        run_check("slt1",  8'hA0, 0, 1'b1, 4, 4'b0011, 1);
        run_check("rstx",  8'hC0, 0, 1'b0, 4, 4'b0010, 1);
        run_check("or",    8'hC1, 0, 1'b1, 4, 4'b0100, 1);
        run_check("setb",  8'hC2, 0, 1'b0, 4, 4'b1110, 1);
        chk("setb_mpr", 32'(r_mpr), 32'd0);
        run_check("store", 8'h60, 2, 1'b0, 6, 4'b1000, 0);
        chk("store_mwr", 32'(r_mwr), 32'd3);
        chk("store_seq", 32'(r_seq), 32'o123444);

        // Counter wrap: preload 0xFFFF across a non-retiring edge, retire a beq.
        bus.instr = 8'hE0; bus.zero = 1'b0; bus.mem_pronta = 1'b1;
        @(negedge clk);
        force dut.contador_q = 16'hFFFF;
        adv();
        @(negedge clk);
        release dut.contador_q;
        chk("wrap_pre", 32'(bus.contador_instr), 32'hFFFF);
        adv();
        adv();
        chk("wrap_estado", 32'(bus.estado), 32'd1);
        chk("wrap_cnt", 32'(bus.contador_instr), 32'h0000);
        exp_cnt = 0;

        // halt, then mem_pronta toggling must not move anything.
        bus.instr = 8'hC3;
        @(negedge clk);
        chk("halt_c1", 32'(bus.halt), 32'd0);
        adv();
        @(negedge clk);
        chk("halt_c2", 32'(bus.halt), 32'd0);
        adv();
        chk("halt_c3", 32'(bus.halt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.mem_pronta = i[0];
            @(negedge clk);
            chk("halt_stay", 32'(bus.estado), 32'd6);
            chk("halt_strb", 32'(strb()), 32'h0002);
            adv();
        end
        chk("halt_cnt", 32'(bus.contador_instr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("halt_rst", 32'({bus.estado, bus.halt}), 32'd0);

        // Reset asserted mid-store while MemWrite is high.
        adv();
        rst_n = 1'b1;
        bus.instr = 8'h60; bus.mem_pronta = 1'b1;
        adv(); adv(); adv(); adv();
        bus.mem_pronta = 1'b0;
        @(negedge clk);
        chk("mem_wr_hi", 32'({bus.estado, bus.MemWrite}), 32'({3'd4, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_wr", 32'(bus.MemWrite), 32'd0);
        chk("async_strb", 32'({bus.estado, strb()}), 32'd0);

        // TIMEOUT=4 instance: mem_pronta held low in BUSCA.
        adv();
        rst4_n = 1'b1;
        chk("to_inicio", 32'(bus4.estado), 32'd0);
        for (int i = 0; i < 4; i++) begin
            adv();
            chk("to_busca", 32'({bus4.estado, bus4.MemRead}), 32'({3'd1, 1'b1}));
        end
        adv();
        chk("to_erro", 32'({bus4.estado, bus4.erro, bus4.MemRead}), 32'({3'd7, 2'b10}));
        adv();
        chk("to_stay", 32'({bus4.estado, bus4.erro}), 32'({3'd7, 1'b1}));
        #2 rst4_n = 1'b0;
        #1;
        chk("to_rst", 32'({bus4.estado, bus4.erro}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
